// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that lets NUM_CORES pipelined cores share one
// single-ported, synchronous-read data memory. Each access takes three
// cycles (IDLE grant, ISSUE to memory, RESP ack/capture) with no overlap.
// A core is stalled from the moment it requests until its ack cycle.

module dmem_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          core_read_en,
    input  logic [NUM_CORES-1:0]          core_write_en,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_address,
    input  logic [NUM_CORES*DATA_W-1:0]   core_write_data,
    output logic [NUM_CORES*DATA_W-1:0]   core_read_data,
    output logic [NUM_CORES-1:0]          core_ack,
    output logic [NUM_CORES-1:0]          core_stall,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic [NUM_CORES-1:0]      req;
    logic [IDX_W-1:0]          last_grant;
    logic [IDX_W-1:0]          owner;
    logic [IDX_W-1:0]          grant_idx;
    logic [IDX_W-1:0]          cand;
    logic                      grant_valid;
    logic [ADDR_W-1:0]         addr_q;
    logic [DATA_W-1:0]         wdata_q;
    logic                      we_q;
    logic [NUM_CORES*DATA_W-1:0] read_data_q;

    // A store takes precedence when a core raises both enables.
    assign req = core_read_en | core_write_en;

    // Round-robin search starting just above the last winner, wrapping at NUM_CORES-1.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = last_grant;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (cand == IDX_W'(NUM_CORES - 1)) begin
                cand = '0;
            end else begin
                cand = cand + IDX_W'(1);
            end
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // State register; reset drops back to IDLE and abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one fixed three-step walk per granted transaction.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's request in IDLE so later input changes cannot disturb the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            last_grant <= IDX_W'(NUM_CORES - 1);
        end else if (state == IDLE && grant_valid) begin
            owner   <= grant_idx;
            addr_q  <= core_address[int'(grant_idx)*ADDR_W +: ADDR_W];
            wdata_q <= core_write_data[int'(grant_idx)*DATA_W +: DATA_W];
            we_q    <= core_write_en[grant_idx];
        end else if (state == RESP) begin
            last_grant <= owner;
        end
    end

    // Load data lands in the owner's slice at the end of the ack cycle and holds until its next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
        end else if (state == RESP && !we_q) begin
            read_data_q[int'(owner)*DATA_W +: DATA_W] <= mem_rdata;
        end
    end

    assign core_read_data = read_data_q;

    // Memory drive and ack decoded from state so reset silences them instantly.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        core_ack  = '0;
        case (state)
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                core_ack[owner] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A requesting core is held until the cycle its ack is pulsed.
    assign core_stall = req & ~core_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a two-core instance backed by a small
// synchronous-read RAM model, plus a four-core instance for rotation order.

module tb_dmem_arbiter;

    logic        clk;
    logic        rst;

    logic [1:0]  core_read_en;
    logic [1:0]  core_write_en;
    logic [63:0] core_address;
    logic [63:0] core_write_data;
    logic [63:0] core_read_data;
    logic [1:0]  core_ack;
    logic [1:0]  core_stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [3:0]   read_en4;
    logic [3:0]   write_en4;
    logic [127:0] address4;
    logic [127:0] write_data4;
    logic [127:0] read_data4;
    logic [3:0]   ack4;
    logic [3:0]   stall4;
    logic         mem_en4;
    logic         mem_we4;
    logic [31:0]  mem_addr4;
    logic [31:0]  mem_wdata4;
    logic [31:0]  mem_rdata4;

    logic [31:0] ram [0:1023];

    int n_checks;
    int n_fail;

    dmem_arbiter #(.NUM_CORES(2), .ADDR_W(32), .DATA_W(32), .IDX_W(1)) u_dut (
        .clk(clk), .rst(rst),
        .core_read_en(core_read_en), .core_write_en(core_write_en),
        .core_address(core_address), .core_write_data(core_write_data),
        .core_read_data(core_read_data), .core_ack(core_ack), .core_stall(core_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .IDX_W(2)) u_dut4 (
        .clk(clk), .rst(rst),
        .core_read_en(read_en4), .core_write_en(write_en4),
        .core_address(address4), .core_write_data(write_data4),
        .core_read_data(read_data4), .core_ack(ack4), .core_stall(stall4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
    );

    assign mem_rdata4 = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: write or read happens on the edge where mem_en is seen.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_read_en    = '0;
        core_write_en   = '0;
        core_address    = '0;
        core_write_data = '0;
        read_en4        = '0;
        write_en4       = '0;
        address4        = '0;
        write_data4     = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #3;
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_en: got %0h expected 0", mem_en); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_we: got %0h expected 0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_wdata: got %0h expected 0", mem_wdata); end
        n_checks++; if (core_ack !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ack: got %0h expected 0", core_ack); end
        n_checks++; if (core_read_data !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_read_data: got %0h expected 0", core_read_data); end
        n_checks++; if (core_stall !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_stall: got %0h expected 0", core_stall); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++; if (mem_en !== 1'b0 || core_ack !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_quiet cycle %0d: got mem_en=%0h ack=%0h expected 0/0", c, mem_en, core_ack); end
        end
    endtask

    task automatic test_single_read();
        core_read_en         = 2'b01;
        core_address[31:0]   = 32'h100;
        #1;
        n_checks++; if (core_stall !== 2'b01) begin n_fail++; $display("[TB] FAIL single_stall_T: got %0h expected 1", core_stall); end
        tick();
        n_checks++; if ({mem_en, mem_we} !== 2'b10) begin n_fail++; $display("[TB] FAIL single_en_we: got %0h expected 2", {mem_en, mem_we}); end
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("[TB] FAIL single_addr: got %0h expected 100", mem_addr); end
        n_checks++; if (core_stall !== 2'b01 || core_ack !== 2'b00) begin n_fail++; $display("[TB] FAIL single_issue_stall_ack: got %0h/%0h expected 1/0", core_stall, core_ack); end
        tick();
        n_checks++; if (core_ack !== 2'b01) begin n_fail++; $display("[TB] FAIL single_ack: got %0h expected 1", core_ack); end
        n_checks++; if (core_stall !== 2'b00 || mem_en !== 1'b0) begin n_fail++; $display("[TB] FAIL single_resp_stall_en: got %0h/%0h expected 0/0", core_stall, mem_en); end
        core_read_en = 2'b00;
        tick();
        n_checks++; if (core_read_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL single_rdata: got %0h expected deadbeef", core_read_data[31:0]); end
        n_checks++; if (core_ack !== 2'b00) begin n_fail++; $display("[TB] FAIL single_ack_once: got %0h expected 0", core_ack); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] en_mask;
        logic [15:0] ack0_mask;
        logic [15:0] ack1_mask;
        en_mask = '0; ack0_mask = '0; ack1_mask = '0;
        do_reset();
        core_write_en         = 2'b01;
        core_address[31:0]    = 32'h10;
        core_write_data[31:0] = 32'h11;
        core_read_en          = 2'b10;
        core_address[63:32]   = 32'h20;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                n_checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h10, 32'h11}) begin n_fail++; $display("[TB] FAIL simul_first_write: got we=%0h addr=%0h data=%0h expected 1/10/11", mem_we, mem_addr, mem_wdata); end
            end
            en_mask[k]   = mem_en;
            ack0_mask[k] = core_ack[0];
            ack1_mask[k] = core_ack[1];
            if (core_ack[0]) core_write_en[0] = 1'b0;
            if (core_ack[1]) core_read_en[1]  = 1'b0;
        end
        n_checks++; if (en_mask !== 16'h0012) begin n_fail++; $display("[TB] FAIL simul_mem_en_cycles: got %0h expected 12", en_mask); end
        n_checks++; if (ack0_mask !== 16'h0004) begin n_fail++; $display("[TB] FAIL simul_ack0_cycle: got %0h expected 4", ack0_mask); end
        n_checks++; if (ack1_mask !== 16'h0020) begin n_fail++; $display("[TB] FAIL simul_ack1_cycle: got %0h expected 20", ack1_mask); end
        n_checks++; if (ram[16] !== 32'h11) begin n_fail++; $display("[TB] FAIL simul_ram_write: got %0h expected 11", ram[16]); end
        n_checks++; if (core_read_data !== {32'hCAFE0020, 32'h0}) begin n_fail++; $display("[TB] FAIL simul_rdata: got %0h expected cafe0020_00000000", core_read_data); end
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[4] = '{0, 1, 0, 1};
        core_read_en        = 2'b11;
        core_address[31:0]  = 32'h100;
        core_address[63:32] = 32'h20;
        for (int c = 0; c < 20 && order.size() < 4; c++) begin
            tick();
            if (core_ack[0]) order.push_back(0);
            if (core_ack[1]) order.push_back(1);
        end
        core_read_en = 2'b00;
        tick();
        n_checks++; if (order.size() != 4) begin n_fail++; $display("[TB] FAIL rr_count: got %0d acks expected 4", order.size()); end
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            n_checks++; if (order[i] != exp_order[i]) begin n_fail++; $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]); end
        end
        n_checks++; if (core_read_data !== {32'hCAFE0020, 32'hDEADBEEF}) begin n_fail++; $display("[TB] FAIL rr_rdata: got %0h expected cafe0020_deadbeef", core_read_data); end
    endtask

    task automatic test_read_write_both();
        core_read_en           = 2'b10;
        core_write_en          = 2'b10;
        core_address[63:32]    = 32'h8;
        core_write_data[63:32] = 32'h55;
        tick();
        n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h8, 32'h55}) begin n_fail++; $display("[TB] FAIL rw_issue: got en=%0h we=%0h addr=%0h data=%0h expected 1/1/8/55", mem_en, mem_we, mem_addr, mem_wdata); end
        tick();
        n_checks++; if (core_ack !== 2'b10) begin n_fail++; $display("[TB] FAIL rw_ack: got %0h expected 2", core_ack); end
        core_read_en  = 2'b00;
        core_write_en = 2'b00;
        tick();
        n_checks++; if (core_read_data[63:32] !== 32'hCAFE0020) begin n_fail++; $display("[TB] FAIL rw_rdata_held: got %0h expected cafe0020", core_read_data[63:32]); end
        n_checks++; if (ram[8] !== 32'h55) begin n_fail++; $display("[TB] FAIL rw_ram: got %0h expected 55", ram[8]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ack_mask;
        ack_mask            = '0;
        core_read_en        = 2'b10;
        core_address[63:32] = 32'h10;
        for (int k = 1; k <= 9; k++) begin
            tick();
            ack_mask[k] = core_ack[1];
        end
        core_read_en = 2'b00;
        tick();
        n_checks++; if (ack_mask !== 16'h0124) begin n_fail++; $display("[TB] FAIL b2b_ack_cycles: got %0h expected 124", ack_mask); end
        n_checks++; if (core_read_data[63:32] !== 32'h11) begin n_fail++; $display("[TB] FAIL b2b_rdata: got %0h expected 11", core_read_data[63:32]); end
    endtask

    task automatic test_owner_drop();
        core_read_en       = 2'b01;
        core_address[31:0] = 32'h20;
        tick();
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h20) begin n_fail++; $display("[TB] FAIL drop_issue: got en=%0h addr=%0h expected 1/20", mem_en, mem_addr); end
        core_read_en = 2'b00;
        tick();
        n_checks++; if (core_ack !== 2'b01) begin n_fail++; $display("[TB] FAIL drop_ack: got %0h expected 1", core_ack); end
        tick();
        n_checks++; if (core_read_data[31:0] !== 32'hCAFE0020) begin n_fail++; $display("[TB] FAIL drop_rdata: got %0h expected cafe0020", core_read_data[31:0]); end
    endtask

    task automatic test_reset_mid_issue();
        core_write_en         = 2'b01;
        core_address[31:0]    = 32'h30;
        core_write_data[31:0] = 32'h77;
        tick();
        n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_issue: got %0h expected 1", mem_en); end
        rst = 1'b1;
        #1;
        n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_instant: got en=%0h we=%0h addr=%0h expected 0/0/0", mem_en, mem_we, mem_addr); end
        n_checks++; if (core_read_data !== 64'h0) begin n_fail++; $display("[TB] FAIL rstmid_rdata: got %0h expected 0", core_read_data); end
        tick();
        n_checks++; if (core_ack !== 2'b00 || mem_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_no_ack: got ack=%0h en=%0h expected 0/0", core_ack, mem_en); end
        rst = 1'b0;
        n_checks++; if (ram[48] !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_aborted: got %0h expected 0", ram[48]); end
        tick();
        n_checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h30}) begin n_fail++; $display("[TB] FAIL rstmid_regrant: got en=%0h we=%0h addr=%0h expected 1/1/30", mem_en, mem_we, mem_addr); end
        tick();
        n_checks++; if (core_ack !== 2'b01) begin n_fail++; $display("[TB] FAIL rstmid_ack: got %0h expected 1", core_ack); end
        core_write_en = 2'b00;
        tick();
        n_checks++; if (ram[48] !== 32'h77) begin n_fail++; $display("[TB] FAIL rstmid_ram: got %0h expected 77", ram[48]); end
    endtask

    task automatic test_four_cores();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        read_en4 = 4'hF;
        for (int c = 0; c < 25 && order.size() < 5; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (ack4[i]) order.push_back(i);
            end
        end
        read_en4 = 4'h0;
        tick();
        n_checks++; if (order.size() != 5) begin n_fail++; $display("[TB] FAIL rr4_count: got %0d acks expected 5", order.size()); end
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            n_checks++; if (order[i] != exp_order[i]) begin n_fail++; $display("[TB] FAIL rr4_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]); end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mem_rdata = '0;
        for (int a = 0; a < 1024; a++) ram[a] = 32'h0;
        ram[256] = 32'hDEADBEEF;
        ram[32]  = 32'hCAFE0020;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_round_robin();
        test_read_write_both();
        test_back_to_back();
        test_owner_drop();
        test_reset_mid_issue();
        test_four_cores();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported data memory between NUM_CORES pipelined cores, using round-robin arbitration.
- Sits between each core's data-memory port (read_en, write_en, address, write_data, read_data) and the shared synchronous-read RAM.
- Asserts per-core stall while a core's access is pending, so the core freezes its pipeline until its ack.

Parameters:
- NUM_CORES, 2, number of requesting cores (2..8).
- ADDR_W, 32, memory address width.
- DATA_W, 32, data width.
- IDX_W, 1, core index width, equal to clog2(NUM_CORES), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- core_read_en  in  NUM_CORES  per-core load request.
- core_write_en  in  NUM_CORES  per-core store request.
- core_address  in  NUM_CORES*ADDR_W  per-core address; core i occupies slice [i*ADDR_W +: ADDR_W].
- core_write_data  in  NUM_CORES*DATA_W  per-core store data, sliced the same way.
- core_read_data  out  NUM_CORES*DATA_W  per-core registered load data.
- core_ack  out  NUM_CORES  one-cycle completion pulse per core.
- core_stall  out  NUM_CORES  per-core hold request to that core's pipeline.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after an enabled read.

Behaviour:
- req[i] = core_read_en[i] | core_write_en[i]. If both are set, the access is a write.
- Core obligations: while core_stall[i] is high, core i holds its request, address and write data stable.
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE:
  - If any req is set, select a winner by round-robin, searching upward (with wrap) from last_grant+1.
  - Register the winner's index, address, write data and kind (read/write).
  - Go to ISSUE.
  - If no req is set, stay in IDLE.
- ISSUE:
  - mem_en=1; mem_we=registered kind; mem_addr and mem_wdata come from the registered values.
  - Go to RESP.
- RESP:
  - core_ack[owner]=1 for exactly this cycle.
  - If the access was a read, capture mem_rdata into the owner's core_read_data slice at the end of this cycle.
  - Set last_grant=owner; go to IDLE.
- Latency: request sampled in IDLE at cycle T → mem_en at T+1 → ack at T+2 → read data visible at T+3. One transaction per 3 cycles, no overlap.
- core_stall[i] = req[i] & ~core_ack[i]. It is combinational and also high in IDLE before the grant.
- core_read_data slices hold their last value until that core's next read ack. Writes never change core_read_data.
- Owner drops its request during ISSUE or RESP: the transaction completes anyway and the ack is still pulsed.
- Non-owner requests raised mid-transaction wait for the next IDLE.
- A single requester is re-granted every 3 cycles regardless of last_grant.
- Fairness: with all cores requesting continuously, no core waits more than NUM_CORES transactions.
- Reset behaviour (asynchronous, any state):
  - Outputs go to 0 immediately: mem_en, mem_we, mem_addr, mem_wdata, core_ack, and all core_read_data slices.
  - State returns to IDLE.
  - last_grant = NUM_CORES-1, so core 0 has priority first.
  - A write interrupted in ISSUE is aborted. mem_en falls the same instant, and no ack is issued.
- Outside ISSUE: mem_en=0 and mem_we=0, with mem_addr and mem_wdata driven to 0.

Test Plan:
- Reset then idle: rst pulse, no requests → all outputs 0, mem_en stays 0 for 10 cycles.
- Single read: core0 read_en, addr 0x100, memory returns 0xDEADBEEF → mem_en/we=1/0 at T+1 with addr 0x100; core_ack[0] at T+2; core_read_data[0]=0xDEADBEEF from T+3; core_stall[0] high T..T+1.
- Simultaneous: core0 write 0x10←0x11 and core1 read 0x20, both from cycle T →
  - core0 is granted first (acked at T+2);
  - core1 is acked at T+5;
  - exactly 2 mem_en pulses, at T+1 and T+4.
- Round-robin rotation: both cores request continuously for 4 transactions → ack order 0,1,0,1. With NUM_CORES=4 and all four requesting, the order is 0,1,2,3,0.
- Read/write both set: core1 read_en=write_en=1, addr 0x8, data 0x55 → mem_we=1, ack at T+2, core_read_data[1] unchanged.
- Reset mid-ISSUE: assert rst while mem_en=1 → mem_en drops in the same cycle, no ack pulse. After release, a pending core0 request is granted anew with 3-cycle latency.
